// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_controller_if.sv
// Byte-side handshake between the UART receiver and its consumer.
interface uart_rx_controller_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] o_rx_data;
  logic                      o_rx_valid;
  logic                      o_rx_active;
  logic                      o_frame_error;
  logic                      o_overrun;
  logic                      i_rx_read;

  modport master (
    output o_rx_data, o_rx_valid, o_rx_active, o_frame_error, o_overrun,
    input  i_rx_read
  );

  modport slave (
    input  o_rx_data, o_rx_valid, o_rx_active, o_frame_error, o_overrun,
    output i_rx_read
  );
endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous serial pin; resets to the idle-high level.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= '1;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_rx_controller.sv
// UART receiver: oversampled 8N1 framing into a holding register with valid/error/overrun status.
//   state | meaning
//   IDLE  | line idle, waiting for a low level
//   START | timing to mid start bit, rejecting glitches
//   DATA  | sampling 8 data bits, LSB first
//   STOP  | sampling the stop bit
//   BREAK | stop bit was low; wait for the line to return high
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_rx_serial,
  uart_rx_controller_if.master rx_if
);
  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(UART_DATA_BITS);
  localparam logic [TICK_W-1:0] HALF     = TICK_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TICK_W-1:0] BIT_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
      $error("uart_rx_controller: CLKS_PER_BIT must be >= 4");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("uart_rx_controller: SYNC_STAGES must be >= 2");
    end
  endgenerate

  uart_state_e               state, state_next;
  logic [TICK_W-1:0]         tick, tick_next;
  logic [IDX_W-1:0]          idx, idx_next;
  logic [UART_DATA_BITS-1:0] shift, shift_next;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid, frame_error, overrun;
  logic                      rx_sync, load_byte, stop_bad;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (i_rx_serial),
    .q     (rx_sync)
  );

  // Timer is a down-counter: loaded on entry, the sample point is terminal count zero.
  always_comb begin
    state_next = state;
    tick_next  = tick;
    idx_next   = idx;
    shift_next = shift;
    load_byte  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_next = START;
          tick_next  = HALF;
        end
      end
      START: begin
        if (tick != '0) begin
          tick_next = tick - TICK_W'(1);
        end else if (!rx_sync) begin
          state_next = DATA;
          tick_next  = BIT_LAST;
          idx_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      DATA: begin
        if (tick != '0) begin
          tick_next = tick - TICK_W'(1);
        end else begin
          shift_next[idx] = rx_sync;
          tick_next       = BIT_LAST;
          if (idx == IDX_LAST) state_next = STOP;
          else                 idx_next   = idx + IDX_W'(1);
        end
      end
      STOP: begin
        if (tick != '0) begin
          tick_next = tick - TICK_W'(1);
        end else if (rx_sync) begin
          load_byte  = 1'b1;
          state_next = IDLE;
        end else begin
          stop_bad   = 1'b1;
          state_next = BREAK;
        end
      end
      BREAK: begin
        if (rx_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tick  <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_next;
      tick  <= tick_next;
      idx   <= idx_next;
      shift <= shift_next;
    end
  end

  // A read landing on the completion edge consumes the old byte, so no overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= stop_bad;
      if (load_byte) begin
        rx_data  <= shift_next;
        rx_valid <= 1'b1;
        overrun  <= rx_valid && !rx_if.i_rx_read;
      end else if (rx_if.i_rx_read && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

  assign rx_if.o_rx_data     = rx_data;
  assign rx_if.o_rx_valid    = rx_valid;
  assign rx_if.o_rx_active   = (state == START) || (state == DATA) || (state == STOP);
  assign rx_if.o_frame_error = frame_error;
  assign rx_if.o_overrun     = overrun;
endmodule

// File: tb/tb_uart_rx_controller.sv
// Scoreboard bench for uart_rx_controller: frames are driven on the pin, expected byte-side status is queued and matched per frame.
module tb_uart_rx_controller;
  localparam int CBP        = 16;
  localparam int SYNC       = 2;
  localparam int HALF       = (CBP - 1) / 2;
  localparam int LAT_DONE   = SYNC + 1 + HALF + 9 * CBP + 1;
  localparam int LAT_GLITCH = SYNC + 1 + HALF + 1;
  localparam int ACTIVE_LEN = LAT_DONE - (SYNC + 1);
  localparam int READ_OFF   = LAT_DONE - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_serial = 1'b1;

  uart_rx_controller_if rx_if ();

  uart_rx_controller #(.CLKS_PER_BIT(CBP), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_rx_serial (rx_serial),
    .rx_if       (rx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int fe_cycles = 0;
  int last_rise = 0;
  logic prev_active = 1'b0;

  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  int rise_q[$];
  int fall_q[$];

  logic [7:0] m_data = 8'h00;
  logic m_valid = 1'b0;
  logic m_ovr = 1'b0;

  function automatic logic [10:0] status();
    return {rx_if.o_rx_data, rx_if.o_rx_valid, rx_if.o_frame_error, rx_if.o_overrun};
  endfunction

  // Each end of a frame (active falling) is captured along with its start.
  always @(negedge clk) begin
    if (reset && prev_active && !rx_if.o_rx_active) begin
      obs_q.push_back(status());
      rise_q.push_back(last_rise);
      fall_q.push_back(cyc);
    end
    if (reset && !prev_active && rx_if.o_rx_active) last_rise = cyc;
    if (rx_if.o_frame_error) fe_cycles++;
    prev_active = rx_if.o_rx_active;
  end

  task automatic model_frame(input logic [7:0] b, input logic good, input logic rd);
    if (good) begin
      m_ovr   = m_valid && !rd;
      m_data  = b;
      m_valid = 1'b1;
      exp_q.push_back({m_data, 1'b1, 1'b0, m_ovr});
    end else begin
      exp_q.push_back({m_data, m_valid, 1'b1, m_ovr});
    end
  endtask

  task automatic flush_queues();
    exp_q.delete(); obs_q.delete(); rise_q.delete(); fall_q.delete();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len,
                            input int read_off, input int abort_at);
    int n;
    int len;
    logic bitv;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      bitv = 1'b0;
      else if (i == 9) bitv = stop_val;
      else             bitv = b[i-1];
      len = (i == 9) ? stop_len : CBP;
      for (int k = 0; k < len; k++) begin
        if (abort_at > 0 && n == abort_at) begin
          rx_serial = 1'b1;
          return;
        end
        rx_serial = bitv;
        rx_if.i_rx_read = (read_off > 0 && n == read_off);
        @(negedge clk);
        n++;
      end
    end
    rx_if.i_rx_read = 1'b0;
    if (abort_at == 0) model_frame(b, stop_val, read_off > 0);
  endtask

  task automatic do_read();
    rx_if.i_rx_read = 1'b1;
    vectors++;
    if (rx_if.o_rx_valid !== m_valid) begin
      miscompares++;
      $display("FAIL valid_before_read: got %b expected %b", rx_if.o_rx_valid, m_valid);
    end
    @(negedge clk);
    rx_if.i_rx_read = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    vectors++;
    if ({rx_if.o_rx_valid, rx_if.o_overrun} !== 2'b00) begin
      miscompares++;
      $display("FAIL read_clear: got valid/ovr %b%b expected 00", rx_if.o_rx_valid, rx_if.o_overrun);
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({status(), rx_if.o_rx_active} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_values: got %h expected 000", {status(), rx_if.o_rx_active});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({status(), rx_if.o_rx_active} !== 12'h000) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %h expected 000", {status(), rx_if.o_rx_active});
    end
  endtask

  task automatic test_basic();
    int t0;
    int rise;
    int fall;
    logic [10:0] e;
    logic [10:0] o;
    t0 = cyc;
    send_frame(8'hA5, 1'b1, CBP, 0, 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++;
      $display("FAIL basic_events: got %0d expected 1", obs_q.size());
      flush_queues();
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      rise = rise_q.pop_front(); fall = fall_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL basic_status: got %h expected %h", o, e);
      end
      vectors++;
      if (fall - t0 != LAT_DONE) begin
        miscompares++;
        $display("FAIL basic_latency: got %0d expected %0d", fall - t0, LAT_DONE);
      end
      vectors++;
      if (fall - rise != ACTIVE_LEN) begin
        miscompares++;
        $display("FAIL basic_active_len: got %0d expected %0d", fall - rise, ACTIVE_LEN);
      end
    end
    do_read();
  endtask

  task automatic test_glitch();
    int t0;
    logic [10:0] o;
    t0 = cyc;
    exp_q.push_back({m_data, m_valid, 1'b0, m_ovr});
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    rx_serial = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++;
      $display("FAIL glitch_events: got %0d expected 1", obs_q.size());
      flush_queues();
    end else begin
      o = obs_q.pop_front();
      void'(rise_q.pop_front());
      vectors++;
      if (o !== exp_q[0]) begin
        miscompares++;
        $display("FAIL glitch_status: got %h expected %h", o, exp_q[0]);
      end
      void'(exp_q.pop_front());
      vectors++;
      if (fall_q[0] - t0 != LAT_GLITCH) begin
        miscompares++;
        $display("FAIL glitch_abort_time: got %0d expected %0d", fall_q[0] - t0, LAT_GLITCH);
      end
      void'(fall_q.pop_front());
    end
  endtask

  task automatic test_frame_error();
    int busy;
    logic [10:0] o;
    fe_cycles = 0;
    busy = 0;
    send_frame(8'h3C, 1'b0, CBP, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (rx_if.o_rx_active) busy++;
      @(negedge clk);
    end
    vectors++;
    if (busy != 0) begin
      miscompares++;
      $display("FAIL break_no_restart: got %0d active cycles expected 0", busy);
    end
    rx_serial = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h01, 1'b1, CBP, 0, 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (fe_cycles != 1) begin
      miscompares++;
      $display("FAIL frame_error_width: got %0d cycles expected 1", fe_cycles);
    end
    vectors++;
    if (obs_q.size() != 2) begin
      miscompares++;
      $display("FAIL ferr_events: got %0d expected 2", obs_q.size());
      flush_queues();
    end else begin
      for (int i = 0; i < 2; i++) begin
        o = obs_q.pop_front();
        void'(rise_q.pop_front()); void'(fall_q.pop_front());
        vectors++;
        if (o !== exp_q[0]) begin
          miscompares++;
          $display("FAIL ferr_status[%0d]: got %h expected %h", i, o, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_overrun();
    logic [10:0] o;
    do_read();
    send_frame(8'h11, 1'b1, CBP, 0, 0);
    send_frame(8'h22, 1'b1, CBP, 0, 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_q.size() != 2) begin
      miscompares++;
      $display("FAIL overrun_events: got %0d expected 2", obs_q.size());
      flush_queues();
    end else begin
      for (int i = 0; i < 2; i++) begin
        o = obs_q.pop_front();
        void'(rise_q.pop_front()); void'(fall_q.pop_front());
        vectors++;
        if (o !== exp_q[0]) begin
          miscompares++;
          $display("FAIL overrun_status[%0d]: got %h expected %h", i, o, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    do_read();
  endtask

  task automatic test_read_on_completion();
    logic [10:0] o;
    send_frame(8'h33, 1'b1, CBP, 0, 0);
    send_frame(8'h44, 1'b1, CBP, 0, 0);
    send_frame(8'h55, 1'b1, CBP, READ_OFF, 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_q.size() != 3) begin
      miscompares++;
      $display("FAIL rdcomp_events: got %0d expected 3", obs_q.size());
      flush_queues();
    end else begin
      for (int i = 0; i < 3; i++) begin
        o = obs_q.pop_front();
        void'(rise_q.pop_front()); void'(fall_q.pop_front());
        vectors++;
        if (o !== exp_q[0]) begin
          miscompares++;
          $display("FAIL rdcomp_status[%0d]: got %h expected %h", i, o, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_back_to_back();
    int rise2;
    int fall1;
    logic [10:0] o;
    do_read();
    send_frame(8'h5A, 1'b1, 9, 0, 0);
    send_frame(8'hC3, 1'b1, CBP, 0, 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_q.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_events: got %0d expected 2", obs_q.size());
      flush_queues();
    end else begin
      void'(rise_q.pop_front());
      fall1 = fall_q.pop_front();
      rise2 = rise_q.pop_front();
      void'(fall_q.pop_front());
      for (int i = 0; i < 2; i++) begin
        o = obs_q.pop_front();
        vectors++;
        if (o !== exp_q[0]) begin
          miscompares++;
          $display("FAIL b2b_status[%0d]: got %h expected %h", i, o, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      vectors++;
      if (rise2 - fall1 != 1) begin
        miscompares++;
        $display("FAIL b2b_idle_gap: got %0d expected 1", rise2 - fall1);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] o;
    send_frame(8'hFF, 1'b1, CBP, 0, 60);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({status(), rx_if.o_rx_active} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_mid_values: got %h expected 000", {status(), rx_if.o_rx_active});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_events: got %0d expected 0", obs_q.size());
      flush_queues();
    end
    send_frame(8'h81, 1'b1, CBP, 0, 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++;
      $display("FAIL post_reset_events: got %0d expected 1", obs_q.size());
      flush_queues();
    end else begin
      o = obs_q.pop_front();
      void'(rise_q.pop_front()); void'(fall_q.pop_front());
      vectors++;
      if (o !== exp_q[0]) begin
        miscompares++;
        $display("FAIL post_reset_status: got %h expected %h", o, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    rx_if.i_rx_read = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_read_on_completion();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
